bin_bcd_display: RTL and testbench
==================================

BIN_BCD_DISPLAY -- requirements
Module: bin_bcd_display

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the binary input width (1..16).
REQ-002 The block SHALL have parameter DIGITS, default 2, giving the number of decimal digits displayed (1..5).
REQ-003 The block SHALL have parameter BLANK_LZ, default 0; when 1, leading zeros are blanked.
REQ-004 Port clock, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: request conversion of bin_in; sampled only in IDLE.
REQ-007 Port bin_in, input, WIDTH: unsigned binary value.
REQ-008 Port enable, input, 1: display enable; low blanks every digit.
REQ-009 Port busy, output, 1: high while a conversion is in progress.
REQ-010 Port done, output, 1: one-cycle pulse when a new result is committed.
REQ-011 Port overflow, output, 1: committed value exceeded 10^DIGITS-1.
REQ-012 Port bcd, output, 4*DIGITS: committed BCD result; digit 0 is in bits [3:0].
REQ-013 Port hex, output, 7*DIGITS: segments for digit k are in bits [7k+6:7k].

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and COMMIT, and reset to IDLE.
REQ-015 IDLE with start=1 SHALL latch bin_in, clear the scratch BCD, clear the sticky overflow flag, load the iteration counter with WIDTH, and go to SHIFT.
REQ-016 Each SHIFT cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, bin} left one bit, then decrement the counter.
REQ-017 A 1 shifted out of the top digit SHALL set the sticky overflow flag.
REQ-018 SHIFT SHALL last exactly WIDTH cycles and then go to COMMIT.
REQ-019 COMMIT SHALL load bcd with the scratch value, or with all-9s if the sticky flag is set.
REQ-020 COMMIT SHALL load overflow from the sticky flag, pulse done, and return to IDLE.
REQ-021 Latency: with start sampled at edge 0, done SHALL be high for the cycle after edge WIDTH+1, and bcd/overflow SHALL be valid from that same edge.
REQ-022 busy SHALL be high in SHIFT and COMMIT and low in IDLE.
REQ-023 start while busy SHALL be ignored, with no queueing.
REQ-024 start in the COMMIT cycle SHALL be ignored.
REQ-025 bcd and overflow SHALL hold their values between commits.
REQ-026 hex SHALL be combinational from the registered bcd, enable and BLANK_LZ.
REQ-027 Segments SHALL be active-low, bit0=a ... bit6=g.
REQ-028 Digit codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; codes 10-15 SHALL display 7'h7F.
REQ-029 enable=0 SHALL force every digit to 7'h7F.
REQ-030 With BLANK_LZ=1, zero digits above the highest non-zero digit SHALL display 7'h7F; digit 0 SHALL always be shown.

Reset
REQ-031 resetn low SHALL, asynchronously and at any time including mid-conversion, force state=IDLE, busy=0, done=0, overflow=0, bcd=0, counter=0 and scratch=0.
REQ-032 Out of reset with enable=1, hex SHALL display 0 on every digit (digit 0 only if BLANK_LZ=1).
REQ-033 The first start after resetn deasserts SHALL be accepted at the first rising edge.

Structure
REQ-034 A shared package/include SHALL hold the FSM state encodings and the segment constants SEG_BLANK=7'h7F and the 0-9 table.
REQ-035 One sub-module, seg7_digit (4-bit code, blank input, 7-bit active-low output), SHALL be instantiated DIGITS times via generate.
REQ-036 The add-3 correction SHALL be a generate loop over DIGITS, not a hand-written truth table.

Verification
REQ-037 WIDTH=6, DIGITS=2: start with bin_in=63 -> busy for 7 cycles, done pulse at edge 7, bcd=8'h63, hex={7'h02,7'h30}, overflow=0.
REQ-038 Exhaustive sweep bin_in=0..63 (WIDTH=6, DIGITS=2) -> bcd matches the decimal value and overflow=0 for every input.
REQ-039 WIDTH=8, DIGITS=2, bin_in=200 -> overflow=1, bcd=8'h99; then bin_in=99 -> overflow=0, bcd=8'h99.
REQ-040 start pulsed at cycles 2 and 5 of a conversion of 10, bin_in changed to 33 -> single done, bcd=8'h10.
REQ-041 resetn dropped at SHIFT cycle 3 -> bcd=0, busy=0 immediately with no done; a restart converts correctly.
REQ-042 BLANK_LZ=1, bin_in=5 -> hex={7'h7F,7'h12}; enable=0 -> hex=14'h3FFF.

Source files
------------

// File: rtl/bin_bcd_display_pkg.sv
// Shared constants for the binary-to-BCD display block: FSM state codes
// and the active-low seven-segment patterns (bit0 = a ... bit6 = g).
package bin_bcd_display_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Segment patterns, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Map one BCD code to its segment pattern; non-decimal codes show blank
    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        case (code)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin_bcd_display_seg7_digit.sv
// One seven-segment digit decoder with a blank override, active-low output.
module seg7_digit
    import bin_bcd_display_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode the code, or force all segments off when blanked
    always_comb begin
        seg = blank ? SEG_BLANK : seg_encode(code);
    end

endmodule

// File: rtl/bin_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with a registered result
// and a combinational seven-segment display of the committed value.
module bin_bcd_display
    import bin_bcd_display_pkg::*;
#(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned BLANK_LZ = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  enable,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]          state;
    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                sticky;

    // Add-3 correction applied to every scratch digit that is 5 or more
    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_add3
        assign adj[4*k+3:4*k] = (scratch[4*k+3:4*k] >= 4'd5) ?
                                (scratch[4*k+3:4*k] + 4'd3) : scratch[4*k+3:4*k];
    end

    assign busy = (state != ST_IDLE);

    // Conversion FSM: latch in IDLE, shift WIDTH times, then commit the result
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CW'(WIDTH);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // the bit leaving the top corrected digit is lost range
                    scratch <= {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
                    bin_sr  <= bin_sr << 1;
                    if (adj[4*DIGITS-1]) begin
                        sticky <= 1'b1;
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    bcd      <= sticky ? {DIGITS{4'h9}} : scratch;
                    overflow <= sticky;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-digit display with enable and optional leading-zero blanking
    for (genvar k = 0; k < int'(DIGITS); k++) begin : g_digit
        logic lz;
        if (k == 0) begin : g_lsd
            assign lz = 1'b0;
        end else begin : g_upper
            assign lz = (BLANK_LZ != 0) && (bcd[4*DIGITS-1:4*k] == '0);
        end
        seg7_digit u_seg (
            .code  (bcd[4*k+3:4*k]),
            .blank (!enable || lz),
            .seg   (hex[7*k+6:7*k])
        );
    end

endmodule

// File: tb/tb_bin_bcd_display.sv
// Directed self-checking bench for bin_bcd_display: three instances
// (6-bit/2-digit, 8-bit/2-digit, 6-bit/2-digit with leading-zero blanking)
// share clock, reset, start and enable.
module tb_bin_bcd_display;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  bin8   = 8'd0;

    logic        busy_a, done_a, ovf_a;
    logic [7:0]  bcd_a;
    logic [13:0] hex_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [13:0] hex_b;
    logic        busy_c, done_c, ovf_c;
    logic [7:0]  bcd_c;
    logic [13:0] hex_c;

    int nchk  = 0;
    int nfail = 0;
    int ndone = 0;

    bin_bcd_display #(.WIDTH(6), .DIGITS(2), .BLANK_LZ(0)) u_a (
        .clock(clock), .resetn(resetn), .start(start), .bin_in(bin8[5:0]),
        .enable(enable), .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .bcd(bcd_a), .hex(hex_a)
    );

    bin_bcd_display #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(0)) u_b (
        .clock(clock), .resetn(resetn), .start(start), .bin_in(bin8),
        .enable(enable), .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .bcd(bcd_b), .hex(hex_b)
    );

    bin_bcd_display #(.WIDTH(6), .DIGITS(2), .BLANK_LZ(1)) u_c (
        .clock(clock), .resetn(resetn), .start(start), .bin_in(bin8[5:0]),
        .enable(enable), .busy(busy_c), .done(done_c), .overflow(ovf_c),
        .bcd(bcd_c), .hex(hex_c)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd_of(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Pulse start for one edge, then wait long enough for every instance to finish
    task automatic convert(input logic [7:0] v);
        @(negedge clock);
        bin8  = v;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_bcd", bcd_a, 8'h00);
        check("rst_hex", hex_a, 14'h2040);
        check("rst_hex_lz", hex_c, 14'h3FC0);

        // Release reset and start at once: first edge must accept it
        resetn = 1'b1;
        bin8   = 8'd63;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("lat_busy", busy_a, 1'b1);
            check("lat_done_early", done_a, 1'b0);
            @(negedge clock);
        end
        check("lat_done", done_a, 1'b1);
        check("lat_busy_end", busy_a, 1'b0);
        check("lat_bcd", bcd_a, 8'h63);
        check("lat_hex", hex_a, 14'h0130);
        check("lat_ovf", ovf_a, 1'b0);
        @(negedge clock);
        check("done_pulse_end", done_a, 1'b0);
        check("bcd_hold", bcd_a, 8'h63);

        // Exhaustive 6-bit sweep
        for (int v = 0; v < 64; v++) begin
            convert(8'(v));
            check("sweep_bcd6", bcd_a, bcd_of(v));
            check("sweep_ovf6", ovf_a, 1'b0);
            check("sweep_bcd8", bcd_b, bcd_of(v));
        end

        // Overflow saturates to all nines
        convert(8'd200);
        check("ovf200_bcd", bcd_b, 8'h99);
        check("ovf200_flag", ovf_b, 1'b1);
        check("trunc8_bcd6", bcd_a, 8'h08);

        // Reset mid-conversion, after the third shift edge
        @(negedge clock);
        bin8  = 8'd37;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_busy_pre", busy_a, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_rst_bcd", bcd_a, 8'h00);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_done", done_a, 1'b0);
        check("mid_rst_bcd8", bcd_b, 8'h00);
        check("mid_rst_ovf8", ovf_b, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        ndone  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done_a) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        check("mid_rst_idle", busy_a, 1'b0);
        convert(8'd37);
        check("restart_bcd6", bcd_a, 8'h37);
        check("restart_bcd8", bcd_b, 8'h37);

        // Largest in-range value clears the overflow flag
        convert(8'd99);
        check("b99_bcd", bcd_b, 8'h99);
        check("b99_ovf", ovf_b, 1'b0);

        // Starts while busy and in COMMIT are dropped
        @(negedge clock);
        bin8  = 8'd10;
        start = 1'b1;
        @(negedge clock);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_a) ndone++;
            if (i == 1) bin8 = 8'd33;
            start = (i == 1 || i == 4 || i == 6);
            @(negedge clock);
        end
        start = 1'b0;
        check("ign_single_done", ndone, 1);
        check("ign_bcd", bcd_a, 8'h10);
        check("ign_idle", busy_a, 1'b0);

        // Display patterns and blanking
        convert(8'd5);
        check("hex5", hex_a, 14'h2012);
        check("hex5_lz", hex_c, 14'h3F92);
        convert(8'd47);
        check("hex47_lz", hex_c, 14'h0CF8);
        convert(8'd40);
        check("hex40_lz", hex_c, 14'h0CC0);
        enable = 1'b0;
        #1;
        check("dis_hex", hex_a, 14'h3FFF);
        check("dis_hex_lz", hex_c, 14'h3FFF);
        enable = 1'b1;
        #1;
        check("en_hex_lz", hex_c, 14'h0CC0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
